// File: rtl/baby_vga_pkg.sv
// Shared types and constants for the baby-VGA framebuffer arbiter.
// The framebuffer is 16 rows of 32 pixels. The RAM returns read data one cycle after the strobe.
// The arbiter is a small six-state FSM.
package baby_vga_pkg;

  localparam int FB_ROWS   = 16;
  localparam int FB_ADDR_W = 4;
  localparam int FB_DATA_W = 32;
  localparam int FB_RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LINE_RD  = 3'd1,
    LINE_CAP = 3'd2,
    CPU_RD   = 3'd3,
    CPU_CAP  = 3'd4,
    CPU_WR   = 3'd5
  } arb_state_e;

endpackage

// File: rtl/baby_vga_fb_arbiter.sv
// Purpose: shares the single-port framebuffer RAM between CPU accesses and per-line
//   scanout fetches. Scanout fetches always have priority.
// Latency: an uncontended line fetch or CPU read pulses its valid output 2 cycles after
//   the request. A line fetch that waits behind a CPU op takes up to 2 extra cycles.
// Backpressure: cpu_req_ready drops whenever the RAM is busy or a line fetch is due.
//   A line_req that cannot start is parked in a one-deep slot, and the newest row wins.
// Optional: define BABY_VGA_ARB_STATS_EN to add a saturating CPU stall counter.
module baby_vga_fb_arbiter
  import baby_vga_pkg::*;
#(
  parameter int ROWS   = FB_ROWS,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  input  logic              line_req,
  input  logic [ADDR_W-1:0] line_row,
  output logic              line_valid,
  output logic [DATA_W-1:0] line_data,
  output logic              line_overrun,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef BABY_VGA_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_stall_cnt
`endif
);

  // Row addresses wrap modulo the framebuffer depth.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(ROWS - 1);

  arb_state_e        state, state_nxt;
  logic              pending;
  logic [ADDR_W-1:0] pend_row;
  logic              mem_en_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] line_q, rdata_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, the RAM command for the next cycle, and the CPU ready.
  always_comb begin
    state_nxt     = state;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = '0;
    cpu_req_ready = 1'b0;
    case (state)
      IDLE: begin
        cpu_req_ready = rst_n && !pending && !line_req;
        if (pending || line_req) begin
          state_nxt    = LINE_RD;
          mem_en_nxt   = 1'b1;
          mem_addr_nxt = pending ? pend_row : line_row;
        end else if (cpu_req_valid) begin
          state_nxt     = cpu_req_we ? CPU_WR : CPU_RD;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = cpu_req_we;
          mem_addr_nxt  = cpu_req_addr;
          mem_wdata_nxt = cpu_req_we ? cpu_req_wdata : '0;
        end
      end
      LINE_RD:  state_nxt = LINE_CAP;
      LINE_CAP: state_nxt = IDLE;
      CPU_RD:   state_nxt = CPU_CAP;
      CPU_CAP:  state_nxt = IDLE;
      CPU_WR:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Registered RAM command outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt & ADDR_MASK;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  // One-deep parking slot for line requests that cannot start immediately.
  // If a new request arrives in the cycle the slot is consumed, the slot refills without an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending      <= 1'b0;
      pend_row     <= '0;
      line_overrun <= 1'b0;
    end else if (line_req && (state != IDLE || pending)) begin
      pending  <= 1'b1;
      pend_row <= line_row;
      if (pending && state != IDLE) line_overrun <= 1'b1;
    end else if (state == IDLE && pending) begin
      pending <= 1'b0;
    end
  end

  // Hold the most recent line and CPU read data between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (state == LINE_CAP) line_q  <= mem_rdata;
      if (state == CPU_CAP)  rdata_q <= mem_rdata;
    end
  end

  // In the capture cycle, bypass the RAM output so that the data is presented in the same cycle as the pulse.
  always_comb begin
    line_valid    = (state == LINE_CAP);
    cpu_rsp_valid = (state == CPU_CAP);
    line_data     = (state == LINE_CAP) ? mem_rdata : line_q;
    cpu_rsp_rdata = (state == CPU_CAP)  ? mem_rdata : rdata_q;
  end

`ifdef BABY_VGA_ARB_STATS_EN
  // Saturating count of cycles in which the CPU is held off.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cpu_stall_cnt <= '0;
    else if (cpu_req_valid && !cpu_req_ready && cpu_stall_cnt != 16'hFFFF)
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_baby_vga_fb_arbiter.sv
// Directed bench for baby_vga_fb_arbiter. The bench includes a behavioural framebuffer RAM.
// Inputs change 1 ns after the rising edge. Outputs are checked 1 ns later.
// Cycle N is the interval that starts at rising edge N.
module tb_baby_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid, cpu_req_we;
  logic [3:0]  cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_req_ready, cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic        line_req;
  logic [3:0]  line_row;
  logic        line_valid;
  logic [31:0] line_data;
  logic        line_overrun;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
`ifdef BABY_VGA_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt;
`endif

  logic [31:0] ram [16];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  baby_vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_rdata(cpu_rsp_rdata),
    .line_req(line_req), .line_row(line_row),
    .line_valid(line_valid), .line_data(line_data), .line_overrun(line_overrun),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef BABY_VGA_ARB_STATS_EN
    , .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );

  // Synchronous single-port RAM with a one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'hA500_0000 | i;
    ram[3] = 32'hDEADBEEF;
    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = 4'd0;
    cpu_req_wdata = 32'h0; line_req = 1'b0; line_row = 4'd0;

    // Check the outputs while reset is held.
    repeat (3) tick();
    chk("rst_ready",   {31'b0, cpu_req_ready}, 32'd0);
    chk("rst_rsp",     {31'b0, cpu_rsp_valid}, 32'd0);
    chk("rst_lv",      {31'b0, line_valid},    32'd0);
    chk("rst_mem_en",  {31'b0, mem_en},        32'd0);
    chk("rst_addr",    {28'b0, mem_addr},      32'd0);
    chk("rst_overrun", {31'b0, line_overrun},  32'd0);
    chk("rst_ldata",   line_data,              32'd0);
`ifdef BABY_VGA_ARB_STATS_EN
    chk("rst_stall", {16'b0, cpu_stall_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Test 1: idle CPU read of row 3.
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 4'd3; settle();
    chk("t1_ready", {31'b0, cpu_req_ready}, 32'd1);
    tick(); cpu_req_valid = 1'b0;
    chk("t1_mem_en", {31'b0, mem_en}, 32'd1);
    chk("t1_mem_we", {31'b0, mem_we}, 32'd0);
    chk("t1_addr", {28'b0, mem_addr}, 32'd3);
    chk("t1_rsp_c1", {31'b0, cpu_rsp_valid}, 32'd0);
    tick();
    chk("t1_rsp", {31'b0, cpu_rsp_valid}, 32'd1);
    chk("t1_rdata", cpu_rsp_rdata, 32'hDEADBEEF);
    tick();
    chk("t1_rsp_pulse", {31'b0, cpu_rsp_valid}, 32'd0);
    chk("t1_rdata_hold", cpu_rsp_rdata, 32'hDEADBEEF);
    chk("t1_mem_idle", {31'b0, mem_en}, 32'd0);

    // Test 2: write row 5, then read it back.
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 4'd5; cpu_req_wdata = 32'h0F0F0F0F; settle();
    chk("t2_wr_ready", {31'b0, cpu_req_ready}, 32'd1);
    tick(); cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
    chk("t2_mem_we", {31'b0, mem_en & mem_we}, 32'd1);
    chk("t2_wdata", mem_wdata, 32'h0F0F0F0F);
    chk("t2_waddr", {28'b0, mem_addr}, 32'd5);
    tick();
    chk("t2_no_rsp", {31'b0, cpu_rsp_valid}, 32'd0);
    cpu_req_valid = 1'b1; cpu_req_addr = 4'd5; settle();
    chk("t2_rd_ready", {31'b0, cpu_req_ready}, 32'd1);
    tick(); cpu_req_valid = 1'b0;
    tick();
    chk("t2_rsp", {31'b0, cpu_rsp_valid}, 32'd1);
    chk("t2_rdata", cpu_rsp_rdata, 32'h0F0F0F0F);
    tick();

    // Test 3: line_req for row 7 collides with a CPU read, and the line wins.
    line_req = 1'b1; line_row = 4'd7;
    cpu_req_valid = 1'b1; cpu_req_addr = 4'd3; settle();
    chk("t3_ready0", {31'b0, cpu_req_ready}, 32'd0);
    tick(); line_req = 1'b0;
    chk("t3_mem_addr", {28'b0, mem_addr}, 32'd7);
    chk("t3_ready_c1", {31'b0, cpu_req_ready}, 32'd0);
    tick();
    chk("t3_lv", {31'b0, line_valid}, 32'd1);
    chk("t3_ldata", line_data, 32'hA500_0007);
    chk("t3_no_rsp", {31'b0, cpu_rsp_valid}, 32'd0);
    tick();
    chk("t3_ready_c3", {31'b0, cpu_req_ready}, 32'd1);
    tick(); cpu_req_valid = 1'b0;
    tick();
    chk("t3_rsp", {31'b0, cpu_rsp_valid}, 32'd1);
    chk("t3_rdata", cpu_rsp_rdata, 32'hDEADBEEF);
    chk("t3_ldata_hold", line_data, 32'hA500_0007);
    chk("t3_lv_low", {31'b0, line_valid}, 32'd0);
    tick();

    // Test 4: a line_req arrives while a CPU read is in flight, so the line fetch is deferred.
    cpu_req_valid = 1'b1; cpu_req_addr = 4'd5; settle();
    chk("t4_ready", {31'b0, cpu_req_ready}, 32'd1);
    tick(); cpu_req_valid = 1'b0; line_req = 1'b1; line_row = 4'd2;
    tick(); line_req = 1'b0;
    chk("t4_rsp", {31'b0, cpu_rsp_valid}, 32'd1);
    chk("t4_rdata", cpu_rsp_rdata, 32'h0F0F0F0F);
    chk("t4_lv_c2", {31'b0, line_valid}, 32'd0);
    tick();
    chk("t4_ready_pend", {31'b0, cpu_req_ready}, 32'd0);
    tick();
    chk("t4_mem_addr", {28'b0, mem_addr}, 32'd2);
    chk("t4_mem_en", {31'b0, mem_en}, 32'd1);
    tick();
    chk("t4_lv", {31'b0, line_valid}, 32'd1);
    chk("t4_ldata", line_data, 32'hA500_0002);
    chk("t4_overrun", {31'b0, line_overrun}, 32'd0);
    tick();

    // Test 5: two line_reqs during one CPU read. Only the newer row (9) is fetched.
    cpu_req_valid = 1'b1; cpu_req_addr = 4'd3; settle();
    tick(); cpu_req_valid = 1'b0; line_req = 1'b1; line_row = 4'd1;
    tick(); line_row = 4'd9;
    tick(); line_req = 1'b0;
    chk("t5_overrun", {31'b0, line_overrun}, 32'd1);
    tick();
    chk("t5_mem_addr", {28'b0, mem_addr}, 32'd9);
    tick();
    chk("t5_lv", {31'b0, line_valid}, 32'd1);
    chk("t5_ldata", line_data, 32'hA500_0009);
    tick();
    chk("t5_lv_once", {31'b0, line_valid}, 32'd0);
    tick();
    chk("t5_no_refetch", {31'b0, mem_en}, 32'd0);
    chk("t5_lv_none", {31'b0, line_valid}, 32'd0);

    // Test 6: reset in the cycle after a CPU read is accepted.
    cpu_req_valid = 1'b1; cpu_req_addr = 4'd3; settle();
    tick(); cpu_req_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("t6_rsp", {31'b0, cpu_rsp_valid}, 32'd0);
    chk("t6_mem_en", {31'b0, mem_en}, 32'd0);
    chk("t6_overrun", {31'b0, line_overrun}, 32'd0);
    chk("t6_rdata", cpu_rsp_rdata, 32'd0);
    chk("t6_ldata", line_data, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_ready", {31'b0, cpu_req_ready}, 32'd1);
    chk("t6_rsp_after", {31'b0, cpu_rsp_valid}, 32'd0);
    tick();
    chk("t6_rsp_late", {31'b0, cpu_rsp_valid}, 32'd0);

`ifdef BABY_VGA_ARB_STATS_EN
    // Hold the CPU off with continuous line requests until the counter saturates.
    cpu_req_valid = 1'b1; line_req = 1'b1; line_row = 4'd4;
    repeat (70000) tick();
    chk("t6_stall_sat", {16'b0, cpu_stall_cnt}, 32'h0000FFFF);
    cpu_req_valid = 1'b0; line_req = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
